// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - Bus widths, hold-code encoding and the NOP used as a bubble when no
//     fetched instruction is available.
//   - Fetch FSM state encoding and the {addr, inst} prefetch entry layout.
package pc_fetch_unit_pkg;

    localparam int CPU_W       = 32;
    localparam int HOLD_FLAG_W = 3;

    // Hold codes from the control unit. Any code at or above HOLD_EN
    // freezes the fetch stage.
    localparam logic [HOLD_FLAG_W-1:0] HOLD_NONE = 3'b000;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_EN   = 3'b001;

    // addi x0, x0, 0
    localparam logic [CPU_W-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [CPU_W-1:0] addr;
        logic [CPU_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic hold_active(input logic [HOLD_FLAG_W-1:0] code);
        return code >= HOLD_EN;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding {addr, inst} pairs between memory and IF/ID.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         drop every entry at the next edge (wins over push/pop)
//   push, din     write one entry; ignored when full unless popping too
//   pop, dout     dout is the head entry; pop advances it (ignored if empty)
//   count         number of valid entries
//   full, empty   occupancy flags
module pc_fetch_unit_fetch_fifo
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  fetch_entry_t              din,
    input  logic                      pop,
    output fetch_entry_t              dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE   = 1;

    fetch_entry_t     mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_DEPTH);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage needs no reset: the pointers define what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues one outstanding read at a time over a req/ack
// handshake, buffers returned words with their addresses in a prefetch
// FIFO, and honours jump redirects and pipeline holds.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   jumpFlagIn, jumpAddrIn    redirect request and word-aligned target
//   holdFlagIn                hold code; >= HOLD_EN freezes fetch
//   memReqOut, memAddrOut     read request / address (stable until ack)
//   memAckIn, memDataIn       ack with same-cycle data
//   instOut, instAddrOut      FIFO head (NOP / 0 when empty)
//   instValidOut              FIFO head valid
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jumpFlagIn,
    input  logic [CPU_W-1:0]       jumpAddrIn,
    input  logic [HOLD_FLAG_W-1:0] holdFlagIn,
    output logic                   memReqOut,
    output logic [CPU_W-1:0]       memAddrOut,
    input  logic                   memAckIn,
    input  logic [CPU_W-1:0]       memDataIn,
    output logic [CPU_W-1:0]       instOut,
    output logic [CPU_W-1:0]       instAddrOut,
    output logic                   instValidOut
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW+1:0] DEPTH_EXT = FIFO_DEPTH[CW+1:0];

    fetch_state_t      state_reg, state_next;
    logic [CPU_W-1:0]  pc_reg, pc_next;
    logic [CPU_W-1:0]  drain_addr_reg, drain_addr_next;

    logic              hold;
    logic              req_live;
    logic              ack;
    logic              pop;
    logic              push;
    logic              free_after;
    logic [CW+1:0]     count_after;

    fetch_entry_t      fifo_din;
    fetch_entry_t      fifo_dout;
    logic [CW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign hold     = hold_active(holdFlagIn);
    // Every non-idle state has a request on the bus; reset withdraws it.
    assign req_live = (state_reg != S_IDLE);
    assign ack      = memAckIn && req_live && !rst;

    assign memReqOut  = req_live && !rst;
    // While draining, the bus keeps the abandoned address; pc already
    // holds the redirect target.
    assign memAddrOut = (state_reg == S_DRAIN) ? drain_addr_reg : pc_reg;

    assign pop  = !fifo_empty && !hold && !jumpFlagIn;
    // The issue rule guarantees room; the full check only guards the FIFO.
    assign push = ack && (state_reg == S_REQ) && !jumpFlagIn && (!fifo_full || pop);

    assign count_after = {1'b0, fifo_count}
                       + {{(CW+1){1'b0}}, push}
                       - {{(CW+1){1'b0}}, pop};
    // A new request is only started if an entry is still free after this
    // cycle's push/pop, so the eventual ack can always be stored.
    assign free_after  = (count_after < DEPTH_EXT);

    assign fifo_din.addr = pc_reg;
    assign fifo_din.inst = memDataIn;

    assign instValidOut = !fifo_empty;
    assign instOut      = fifo_empty ? INST_NOP : fifo_dout.inst;
    assign instAddrOut  = fifo_empty ? '0       : fifo_dout.addr;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;

        if (jumpFlagIn) begin
            pc_next = jumpAddrIn;
            case (state_reg)
                S_REQ: begin
                    if (ack) begin
                        state_next = hold ? S_IDLE : S_REQ;
                    end else begin
                        state_next      = S_DRAIN;
                        drain_addr_next = pc_reg;
                    end
                end
                S_DRAIN: begin
                    if (ack) state_next = hold ? S_IDLE : S_REQ;
                end
                default: begin
                    state_next = hold ? S_IDLE : S_REQ;
                end
            endcase
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (free_after && !hold) state_next = S_REQ;
                end
                S_REQ: begin
                    if (ack) begin
                        pc_next    = pc_reg + 32'd4;
                        state_next = (free_after && !hold) ? S_REQ : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (ack) state_next = hold ? S_IDLE : S_REQ;
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
        end
    end

    pc_fetch_unit_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jumpFlagIn),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table followed by
// hand-written sequences for drain-target replacement and zero-wait
// streaming throughput.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        jumpFlagIn;
    logic [31:0] jumpAddrIn;
    logic [2:0]  holdFlagIn;
    logic        memReqOut;
    logic [31:0] memAddrOut;
    logic        memAckIn;
    logic [31:0] memDataIn;
    logic [31:0] instOut;
    logic [31:0] instAddrOut;
    logic        instValidOut;

    logic        auto_mode;
    logic        ack_drv;
    logic [31:0] data_drv;

    int checks = 0;
    int errors = 0;

    // Zero-wait memory model used for the streaming sequence.
    assign memAckIn  = auto_mode ? memReqOut : ack_drv;
    assign memDataIn = auto_mode ? (32'hA000_0000 | memAddrOut) : data_drv;

    pc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jumpFlagIn   (jumpFlagIn),
        .jumpAddrIn   (jumpAddrIn),
        .holdFlagIn   (holdFlagIn),
        .memReqOut    (memReqOut),
        .memAddrOut   (memAddrOut),
        .memAckIn     (memAckIn),
        .memDataIn    (memDataIn),
        .instOut      (instOut),
        .instAddrOut  (instAddrOut),
        .instValidOut (instValidOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [31:0] jaddr;
        logic [2:0]  hold;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_iaddr;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(
        input logic rs, input logic jm, input logic [31:0] ja,
        input logic [2:0] hd, input logic ak, input logic [31:0] d,
        input logic er, input logic [31:0] ea, input logic ev,
        input logic [31:0] eia, input logic [31:0] ei);
        vec_t v;
        v.rst = rs; v.jmp = jm; v.jaddr = ja; v.hold = hd; v.ack = ak; v.data = d;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_iaddr = eia; v.e_inst = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, away from posedge.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst        = v.rst;
        jumpFlagIn = v.jmp;
        jumpAddrIn = v.jaddr;
        holdFlagIn = v.hold;
        ack_drv    = v.ack;
        data_drv   = v.data;
        #1;
        $display("%s: req=%b addr=%h valid=%b iaddr=%h inst=%h",
                 tag, memReqOut, memAddrOut, instValidOut, instAddrOut, instOut);
        chk({tag, ".req"}, {31'd0, memReqOut}, {31'd0, v.e_req});
        if (v.e_req) chk({tag, ".addr"}, memAddrOut, v.e_addr);
        chk({tag, ".valid"}, {31'd0, instValidOut}, {31'd0, v.e_valid});
        chk({tag, ".iaddr"}, instAddrOut, v.e_iaddr);
        chk({tag, ".inst"}, instOut, v.e_inst);
    endtask

    vec_t vecs[31];
    vec_t seq[3];

    initial begin
        // rst jmp jaddr hold ack data | req addr valid iaddr inst
        vecs[0]  = mk(1,0,32'h0,0,0,32'h0,              0,32'h0,0,32'h0,NOP);
        // zero-wait streaming
        vecs[1]  = mk(0,0,32'h0,0,1,32'h0000_0013,      1,32'h0,0,32'h0,NOP);
        vecs[2]  = mk(0,0,32'h0,0,1,32'h0010_0093,      1,32'h4,1,32'h0,32'h0000_0013);
        vecs[3]  = mk(0,0,32'h0,0,1,32'h0020_0113,      1,32'h8,1,32'h4,32'h0010_0093);
        // hold with in-flight request completing, FIFO fills
        vecs[4]  = mk(0,0,32'h0,1,1,32'h0030_0193,      1,32'hC,1,32'h8,32'h0020_0113);
        vecs[5]  = mk(0,0,32'h0,3,0,32'h0,              0,32'h0,1,32'h8,32'h0020_0113);
        vecs[6]  = mk(0,0,32'h0,1,0,32'h0,              0,32'h0,1,32'h8,32'h0020_0113);
        vecs[7]  = mk(0,0,32'h0,3,0,32'h0,              0,32'h0,1,32'h8,32'h0020_0113);
        vecs[8]  = mk(0,0,32'h0,1,0,32'h0,              0,32'h0,1,32'h8,32'h0020_0113);
        // release: pop 0x8, then 0xC with request to 0x10 outstanding
        vecs[9]  = mk(0,0,32'h0,0,0,32'h0,              0,32'h0,1,32'h8,32'h0020_0113);
        vecs[10] = mk(0,0,32'h0,0,0,32'h0,              1,32'h10,1,32'hC,32'h0030_0193);
        // jump to 0x100 with 0x10 unacked for three cycles
        vecs[11] = mk(0,1,32'h100,0,0,32'h0,            1,32'h10,0,32'h0,NOP);
        vecs[12] = mk(0,0,32'h0,0,0,32'h0,              1,32'h10,0,32'h0,NOP);
        vecs[13] = mk(0,0,32'h0,0,0,32'h0,              1,32'h10,0,32'h0,NOP);
        vecs[14] = mk(0,0,32'h0,0,1,32'hDEAD_BEEF,      1,32'h10,0,32'h0,NOP);
        vecs[15] = mk(0,0,32'h0,0,1,32'hA000_0100,      1,32'h100,0,32'h0,NOP);
        vecs[16] = mk(0,0,32'h0,0,0,32'h0,              1,32'h104,1,32'h100,32'hA000_0100);
        // jump coinciding with ack: 0x104 then 0x20 dropped
        vecs[17] = mk(0,1,32'h20,0,1,32'hA000_0104,     1,32'h104,0,32'h0,NOP);
        vecs[18] = mk(0,0,32'h0,0,0,32'h0,              1,32'h20,0,32'h0,NOP);
        vecs[19] = mk(0,1,32'h100,0,1,32'hA000_0020,    1,32'h20,0,32'h0,NOP);
        vecs[20] = mk(0,0,32'h0,0,1,32'hA000_0100,      1,32'h100,0,32'h0,NOP);
        vecs[21] = mk(0,0,32'h0,0,0,32'h0,              1,32'h104,1,32'h100,32'hA000_0100);
        // pc wrap
        vecs[22] = mk(0,1,32'hFFFF_FFFC,0,0,32'h0,      1,32'h104,0,32'h0,NOP);
        vecs[23] = mk(0,0,32'h0,0,1,32'hBAD0_BAD0,      1,32'h104,0,32'h0,NOP);
        vecs[24] = mk(0,0,32'h0,0,1,32'hA000_FFFC,      1,32'hFFFF_FFFC,0,32'h0,NOP);
        vecs[25] = mk(0,0,32'h0,0,1,32'hA000_0000,      1,32'h0,1,32'hFFFF_FFFC,32'hA000_FFFC);
        vecs[26] = mk(0,0,32'h0,0,1,32'hA000_0004,      1,32'h4,1,32'h0,32'hA000_0000);
        // reset mid-request with ack in the reset cycle
        vecs[27] = mk(1,0,32'h0,0,1,32'h5555_5555,      0,32'h0,1,32'h4,32'hA000_0004);
        vecs[28] = mk(0,0,32'h0,0,0,32'h0,              1,32'h0,0,32'h0,NOP);
        vecs[29] = mk(0,0,32'h0,0,1,32'h0000_0013,      1,32'h0,0,32'h0,NOP);
        vecs[30] = mk(0,0,32'h0,0,0,32'h0,              1,32'h4,1,32'h0,32'h0000_0013);

        // jump while draining replaces the target
        seq[0] = mk(0,1,32'h200,0,0,32'h0,              1,32'h4,0,32'h0,NOP);
        seq[1] = mk(0,1,32'h300,0,0,32'h0,              1,32'h4,0,32'h0,NOP);
        seq[2] = mk(0,0,32'h0,0,1,32'hBAD0_0004,        1,32'h4,0,32'h0,NOP);

        auto_mode  = 1'b0;
        rst        = 1'b1;
        jumpFlagIn = 1'b0;
        jumpAddrIn = '0;
        holdFlagIn = HOLD_NONE;
        ack_drv    = 1'b0;
        data_drv   = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 3; i++)  run_vec(seq[i], $sformatf("drain%0d", i));

        // Zero-wait streaming from 0x300: one instruction per cycle.
        @(negedge clk);
        ack_drv    = 1'b0;
        jumpFlagIn = 1'b0;
        holdFlagIn = HOLD_NONE;
        auto_mode  = 1'b1;
        #1;
        $display("stream start: req=%b addr=%h valid=%b", memReqOut, memAddrOut, instValidOut);
        chk("stream.first_addr", memAddrOut, 32'h300);
        chk("stream.first_valid", {31'd0, instValidOut}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ea;
            ea = 32'h300 + 32'(4 * k);
            @(negedge clk);
            #1;
            $display("stream%0d: addr=%h valid=%b iaddr=%h inst=%h",
                     k, memAddrOut, instValidOut, instAddrOut, instOut);
            chk($sformatf("stream%0d.valid", k), {31'd0, instValidOut}, 32'd1);
            chk($sformatf("stream%0d.iaddr", k), instAddrOut, ea);
            chk($sformatf("stream%0d.inst", k), instOut, 32'hA000_0000 | ea);
            chk($sformatf("stream%0d.addr", k), memAddrOut, ea + 32'd4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
